// File: rtl/wishbone_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_master_pkg
// Purpose  : Shared types and lane helpers for the Wishbone master bridge.
// Revision : 1.0 - initial release
// ============================================================================
package wishbone_master_pkg;

    // Access width of a load/store request; 2'd3 is not a legal size.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    // Completion status reported with every response pulse.
    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_BUS        = 2'd1,
        ERR_MISALIGNED = 2'd2,
        ERR_TIMEOUT    = 2'd3
    } err_t;

    // Bridge control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when the address cannot be served by a single aligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic r;
        r = 1'b1;
        case (size)
            SIZE_BYTE: r = 1'b0;
            SIZE_HALF: r = addr_lo[0];
            SIZE_WORD: r = (addr_lo != 2'b00);
            default:   r = 1'b1;
        endcase
        return r;
    endfunction

    // Byte-enable mask for an aligned access.
    function automatic logic [3:0] sel_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SIZE_BYTE: m = 4'b0001 << addr_lo;
            SIZE_HALF: m = 4'b0011 << addr_lo;
            SIZE_WORD: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

    // Move right-aligned store data onto the lanes selected by sel_mask.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [1:0] addr_lo,
                                                input logic [31:0] wdata);
        logic [31:0] d;
        d = 32'h0;
        case (size)
            SIZE_BYTE: d = {24'h0, wdata[7:0]} << {addr_lo, 3'b000};
            SIZE_HALF: d = {16'h0, wdata[15:0]} << {addr_lo[1], 4'b0000};
            SIZE_WORD: d = wdata;
            default:   d = 32'h0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wishbone_interface.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_interface
// Purpose  : Classic Wishbone signal bundle with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface wishbone_interface;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_mosi;
    logic [31:0] dat_miso;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, adr, sel, dat_mosi,
        input  dat_miso, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_mosi,
        output dat_miso, ack, err
    );
endinterface
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// ============================================================================
// Module   : wb_load_align
// Purpose  : Extracts the addressed lane from a read word and sign- or
//            zero-extends it to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module wb_load_align
    import wishbone_master_pkg::*;
(
    input  logic [31:0] i_dat_miso,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the lane and extend it by its top bit unless an unsigned load.
    always_comb begin
        w_byte  = 8'(i_dat_miso >> {i_addr_lo, 3'b000});
        w_half  = 16'(i_dat_miso >> {i_addr_lo[1], 4'b0000});
        o_rdata = i_dat_miso;
        case (i_size)
            SIZE_BYTE: o_rdata = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SIZE_HALF: o_rdata = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default:   o_rdata = i_dat_miso;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wishbone_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_master_bridge
// Purpose  : Turns one load/store request at a time into a single classic
//            Wishbone cycle, with lane alignment, load extension and a
//            no-responder timeout.
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_master_bridge
    import wishbone_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    wishbone_interface.master wishbone
);

    // Wide enough to hold TIMEOUT_CYCLES, so the counter never wraps.
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_req_ready;
    logic               w_misaligned;
    logic               w_cnt_last;
    logic [31:0]        w_load_data;

    // Latched request attributes needed after acceptance.
    logic               r_req_we;
    logic [1:0]         r_req_addr_lo;
    logic [1:0]         r_req_size;
    logic               r_req_unsigned;

    logic [c_CNT_W-1:0] r_cnt;

    logic               r_cyc;
    logic               r_stb;
    logic               r_wb_we;
    logic [31:0]        r_adr;
    logic [3:0]         r_sel;
    logic [31:0]        r_dat_mosi;

    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    err_t               r_rsp_err;

    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign w_cnt_last   = (r_cnt == c_CNT_LAST);

    wb_load_align u_load_align (
        .i_dat_miso (wishbone.dat_miso),
        .i_addr_lo  (r_req_addr_lo),
        .i_size     (r_req_size),
        .i_unsigned (r_req_unsigned),
        .o_rdata    (w_load_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; ready depends on state alone.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = w_misaligned ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (wishbone.err || wishbone.ack || w_cnt_last) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request latch, bus drive, timeout counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_we       <= 1'b0;
            r_req_addr_lo  <= 2'b00;
            r_req_size     <= 2'b00;
            r_req_unsigned <= 1'b0;
            r_cnt          <= '0;
            r_cyc          <= 1'b0;
            r_stb          <= 1'b0;
            r_wb_we        <= 1'b0;
            r_adr          <= 32'h0;
            r_sel          <= 4'h0;
            r_dat_mosi     <= 32'h0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= 32'h0;
            r_rsp_err      <= ERR_OK;
        end else begin
            // Response fields are only non-zero during the single pulse.
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= ERR_OK;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req_we       <= req_we;
                        r_req_addr_lo  <= req_addr[1:0];
                        r_req_size     <= req_size;
                        r_req_unsigned <= req_unsigned;
                        if (w_misaligned) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= ERR_MISALIGNED;
                        end else begin
                            r_cyc      <= 1'b1;
                            r_stb      <= 1'b1;
                            r_wb_we    <= req_we;
                            r_adr      <= {req_addr[31:2], 2'b00};
                            r_sel      <= sel_mask(req_size, req_addr[1:0]);
                            r_dat_mosi <= req_we ? store_lanes(req_size, req_addr[1:0], req_wdata)
                                                 : 32'h0;
                            r_cnt      <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    // err outranks a simultaneous ack; timeout only if neither.
                    if (wishbone.err) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_BUS;
                    end else if (wishbone.ack) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_OK;
                        r_rsp_rdata <= r_req_we ? 32'h0 : w_load_data;
                    end else if (w_cnt_last) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_TIMEOUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready         = w_req_ready;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_rdata         = r_rsp_rdata;
    assign rsp_err           = r_rsp_err;
    assign wishbone.cyc      = r_cyc;
    assign wishbone.stb      = r_stb;
    assign wishbone.we       = r_wb_we;
    assign wishbone.adr      = r_adr;
    assign wishbone.sel      = r_sel;
    assign wishbone.dat_mosi = r_dat_mosi;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wishbone_master_bridge
// Purpose  : Randomized and directed checks of wishbone_master_bridge against
//            a transaction-level model with a programmable slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wishbone_master_bridge;

    localparam int TMO    = 8;
    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_BOTH = 2;
    localparam int M_NONE = 3;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    wishbone_interface wb_if ();

    wishbone_master_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .wishbone     (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int mismatches = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            mismatches++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- programmable slave ----------------
    int          slv_mode  = M_ACK;
    int          slv_delay = 1;
    logic [31:0] slv_data  = 32'h0;
    logic        s_ack, s_err;
    int          s_cnt;

    // Answers after slv_delay strobed edges with ack, err or both.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            s_cnt <= 0;
        end else begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            if (wb_if.cyc && wb_if.stb && !s_ack && !s_err) begin
                if (slv_mode != M_NONE && s_cnt + 1 >= slv_delay) begin
                    s_ack <= (slv_mode == M_ACK) || (slv_mode == M_BOTH);
                    s_err <= (slv_mode == M_ERR) || (slv_mode == M_BOTH);
                    s_cnt <= 0;
                end else begin
                    s_cnt <= s_cnt + 1;
                end
            end else if (!wb_if.cyc) begin
                s_cnt <= 0;
            end
        end
    end

    assign wb_if.ack      = s_ack;
    assign wb_if.err      = s_err;
    assign wb_if.dat_miso = slv_data;

    // ---------------- behavioural model ----------------
    function automatic int m_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        return (addr % m_bytes(size)) != 0;
    endfunction

    function automatic logic [31:0] m_mask(input int nb);
        return (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    endfunction

    function automatic logic [3:0] m_sel(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] s;
        s = ((32'd1 << m_bytes(size)) - 32'd1) << (addr % 4);
        return s[3:0];
    endfunction

    function automatic logic [31:0] m_dat(input logic [1:0] size, input logic [31:0] addr,
                                          input logic [31:0] wdata);
        return (wdata & m_mask(m_bytes(size))) << (8 * (addr % 4));
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] miso, input logic [31:0] addr,
                                           input logic [1:0] size, input logic uns);
        int          nb;
        logic [31:0] lane;
        nb = m_bytes(size);
        if (nb == 4) return miso;
        lane = (miso >> (8 * (addr % 4))) & m_mask(nb);
        if (!uns && lane[8 * nb - 1]) lane = lane | ~m_mask(nb);
        return lane;
    endfunction

    // Expectations of the transaction in flight.
    int          e_n;
    logic [31:0] e_rdata;
    logic [1:0]  e_err;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [31:0] e_dat;

    bit pending = 1'b0;
    bit active  = 1'b0;
    bit done    = 1'b0;
    int rel     = 0;

    // Observations used by the directed literal checks.
    int          obs_cyc_cnt;
    int          obs_rsp_rel;
    logic [3:0]  obs_sel;
    logic [31:0] obs_dat;
    logic        obs_we;
    logic [31:0] obs_rdata;
    logic [1:0]  obs_err;

    // Per-cycle comparison of every output against the model, 1 after the edge.
    always @(posedge clk) begin
        bit exp_cyc, exp_rsp;
        #1;
        if (rst) begin
            pending = 1'b0;
            active  = 1'b0;
            chk("rst_cyc", wb_if.cyc, 0);
            chk("rst_stb", wb_if.stb, 0);
            chk("rst_we", wb_if.we, 0);
            chk("rst_adr", wb_if.adr, 0);
            chk("rst_sel", wb_if.sel, 0);
            chk("rst_dat_mosi", wb_if.dat_mosi, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_req_ready", req_ready, 1);
        end else begin
            if (pending) begin
                pending     = 1'b0;
                active      = 1'b1;
                rel         = 0;
                obs_cyc_cnt = 0;
            end else if (active) begin
                rel++;
            end
            exp_cyc = active && (rel < e_n);
            exp_rsp = active && (rel == e_n);
            chk("req_ready", req_ready, !active);
            chk("cyc", wb_if.cyc, exp_cyc);
            chk("stb", wb_if.stb, exp_cyc);
            if (wb_if.cyc) begin
                obs_cyc_cnt++;
                obs_sel = wb_if.sel;
                obs_dat = wb_if.dat_mosi;
                obs_we  = wb_if.we;
            end
            if (exp_cyc) begin
                chk("adr", wb_if.adr, e_adr);
                chk("sel", wb_if.sel, e_sel);
                chk("we", wb_if.we, e_we);
                if (e_we) chk("dat_mosi", wb_if.dat_mosi, e_dat);
            end
            chk("rsp_valid", rsp_valid, exp_rsp);
            chk("rsp_rdata", rsp_rdata, exp_rsp ? e_rdata : 32'h0);
            chk("rsp_err", rsp_err, exp_rsp ? e_err : 2'd0);
            if (exp_rsp) begin
                obs_rsp_rel = rel;
                obs_rdata   = rsp_rdata;
                obs_err     = rsp_err;
                active      = 1'b0;
                done        = 1'b1;
            end
        end
    end

    // Present one request at a negedge and record what the model expects.
    task automatic start_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata, input int mode,
                             input int delay, input logic [31:0] miso);
        bit answered;
        slv_mode     = mode;
        slv_delay    = delay;
        slv_data     = miso;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        e_adr = addr & 32'hFFFF_FFFC;
        e_we  = we;
        e_sel = m_sel(size, addr);
        e_dat = m_dat(size, addr, wdata);
        if (m_misaligned(size, addr)) begin
            e_n     = 0;
            e_err   = 2'd2;
            e_rdata = 32'h0;
        end else begin
            answered = (mode != M_NONE) && (delay + 1 <= TMO);
            e_n      = answered ? delay + 1 : TMO;
            e_err    = !answered ? 2'd3 : (mode == M_ACK) ? 2'd0 : 2'd1;
            e_rdata  = (answered && mode == M_ACK && !we) ? m_load(miso, addr, size, uns) : 32'h0;
        end
        obs_sel = 4'h0;
        obs_dat = 32'h0;
        obs_we  = 1'b0;
        done    = 1'b0;
        pending = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        if (!done) begin
            chk("rsp_wait_expired", 0, 1);
            active = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata, input int mode,
                           input int delay, input logic [31:0] miso);
        start_txn(we, addr, size, uns, wdata, mode, delay, miso);
        wait_done();
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Word load, registered-ack slave.
        run_txn(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0, M_ACK, 1, 32'h15);
        chk("lit_word_rdata", obs_rdata, 32'h15);
        chk("lit_word_err", obs_err, 2'd0);
        chk("lit_word_sel", obs_sel, 4'b1111);
        chk("lit_word_cyc_cycles", obs_cyc_cnt, 2);
        chk("lit_word_latency", obs_rsp_rel, 2);

        // Byte store to the top lane.
        run_txn(1'b1, 32'h1234_5603, 2'd0, 1'b0, 32'h0000_00AB, M_ACK, 1, 32'hFFFF_FFFF);
        chk("lit_bst_sel", obs_sel, 4'b1000);
        chk("lit_bst_dat", obs_dat, 32'hAB00_0000);
        chk("lit_bst_we", obs_we, 1'b1);
        chk("lit_bst_rdata", obs_rdata, 32'h0);
        chk("lit_bst_err", obs_err, 2'd0);

        // Half loads from the upper lane, signed and unsigned.
        run_txn(1'b0, 32'h0000_2002, 2'd1, 1'b0, 32'h0, M_ACK, 2, 32'h8001_1234);
        chk("lit_half_signed", obs_rdata, 32'hFFFF_8001);
        run_txn(1'b0, 32'h0000_2002, 2'd1, 1'b1, 32'h0, M_ACK, 1, 32'h8001_1234);
        chk("lit_half_unsigned", obs_rdata, 32'h0000_8001);

        // Misaligned word.
        run_txn(1'b0, 32'h0000_3002, 2'd2, 1'b0, 32'h0, M_ACK, 1, 32'h0);
        chk("lit_mis_err", obs_err, 2'd2);
        chk("lit_mis_cyc_cycles", obs_cyc_cnt, 0);
        chk("lit_mis_latency", obs_rsp_rel, 0);

        // Slave error, and ack with err together.
        run_txn(1'b0, 32'h0000_4000, 2'd2, 1'b0, 32'h0, M_ERR, 1, 32'h5555_5555);
        chk("lit_err_err", obs_err, 2'd1);
        chk("lit_err_rdata", obs_rdata, 32'h0);
        run_txn(1'b0, 32'h0000_4004, 2'd2, 1'b0, 32'h0, M_BOTH, 3, 32'h5555_5555);
        chk("lit_both_err", obs_err, 2'd1);

        // No responder, and an ack landing exactly on the last BUS cycle.
        run_txn(1'b0, 32'h0000_5000, 2'd2, 1'b0, 32'h0, M_NONE, 1, 32'h0);
        chk("lit_tmo_err", obs_err, 2'd3);
        chk("lit_tmo_cyc_cycles", obs_cyc_cnt, 8);
        run_txn(1'b0, 32'h0000_5004, 2'd2, 1'b0, 32'h0, M_ACK, 7, 32'h0BAD_F00D);
        chk("lit_late_ack_err", obs_err, 2'd0);
        chk("lit_late_ack_cyc_cycles", obs_cyc_cnt, 8);

        // Reset in the middle of a bus cycle.
        start_txn(1'b0, 32'h0000_6000, 2'd2, 1'b0, 32'h0, M_NONE, 1, 32'h0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_cyc", wb_if.cyc, 0);
        chk("midrst_stb", wb_if.stb, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_txn(1'b0, 32'h0000_6001, 2'd0, 1'b0, 32'h0, M_ACK, 1, 32'h0000_9900);
        chk("lit_after_rst_rdata", obs_rdata, 32'hFFFF_FF99);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            int r, mode;
            r    = int'($urandom_range(0, 9));
            mode = (r < 6) ? M_ACK : (r == 6) ? M_ERR : (r == 7) ? M_BOTH : M_NONE;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, mode,
                    int'($urandom_range(1, 9)), $urandom);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, mismatches);
        $finish;
    end

endmodule
`default_nettype wire
